adc_bcd_capture: RTL and testbench
==================================

ADC_BCD_CAPTURE -- requirements
Module: adc_bcd_capture

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port g_d, input, 1, ADC output-enable strobe from the ADC control stage; adc_d is valid while high.
REQ-004 SHALL have port adc_d, input, 8, ADC0809 parallel data bus.
REQ-005 SHALL have port sample, output, 8, last converted value (raw or averaged).
REQ-006 SHALL have ports bcd_h, bcd_t, bcd_u, output, 4 each, hundreds/tens/units BCD digits of sample.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse when sample and the BCD digits update.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-009 SHALL have port overrun, output, 1, sticky flag: g_d seen while busy.

Function
REQ-010 SHALL implement FSM states IDLE, CONV, DONE.
REQ-011 IDLE: g_d=1 at an edge SHALL latch adc_d into the binary shift register, clear the 3-bit iteration counter and the 12-bit BCD register, and enter CONV.
REQ-012 CONV SHALL perform one double-dabble iteration per cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
REQ-013 CONV SHALL last exactly 8 cycles; after the 8th iteration (counter=7), next state is DONE.
REQ-014 DONE SHALL load sample and bcd_h/t/u, assert valid for that one cycle, and return to IDLE.
REQ-015 Latency: g_d sampled at edge N -> outputs updated and valid high after edge N+9; valid is low at all other times.
REQ-016 busy SHALL be high in CONV and DONE and low in IDLE.
REQ-017 g_d=1 while busy SHALL be ignored for data and SHALL set overrun=1; overrun clears only on rst.
REQ-018 g_d held high for several cycles in IDLE SHALL start only one conversion; a new capture requires g_d low for at least one cycle (edge-qualified).
REQ-019 bcd_h SHALL never exceed 2; every digit SHALL be a legal BCD value (0-9).
REQ-020 sample, bcd_h/t/u SHALL hold their values between valid pulses.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE, and sample=0, bcd_h=bcd_t=bcd_u=0, valid=0, busy=0, overrun=0, and clear the internal shift/BCD registers and counters.
REQ-022 rst during CONV or DONE SHALL abort the conversion with no valid pulse; the first g_d after rst is deasserted SHALL be captured normally.
REQ-023 rst SHALL take priority over g_d in the same cycle.

Configuration
REQ-024 Macro ADC_AVG4_EN SHALL select 4-sample averaging.
REQ-025 With ADC_AVG4_EN defined: each capture SHALL add adc_d to a 10-bit accumulator and increment a 2-bit capture counter; only on the 4th capture SHALL conversion start, on value acc[9:2] (truncating), after which accumulator and counter clear; captures 1-3 SHALL not assert busy or valid.
REQ-026 With ADC_AVG4_EN defined: rst SHALL clear the accumulator and capture counter; overrun rules unchanged.
REQ-027 Without ADC_AVG4_EN: every capture SHALL be converted directly; no accumulator logic is present.

Verification
REQ-028 adc_d=0xFF, one-cycle g_d -> after 9 edges valid=1, sample=0xFF, digits 2,5,5.
REQ-029 adc_d=0x00 -> sample=0x00, digits 0,0,0, valid pulses once; then adc_d=0x7B -> digits 1,2,3.
REQ-030 g_d with 0x64, second g_d with 0x10 three cycles later -> overrun=1, sample=0x64, digits 1,0,0, only one valid.
REQ-031 g_d with 0xC8, rst asserted 4 cycles later -> all outputs 0, no valid; next g_d with 0x2A -> digits 0,4,2.
REQ-032 g_d held high 5 cycles with 0x05 -> exactly one valid, digits 0,0,5, overrun=0.
REQ-033 ADC_AVG4_EN defined, captures 10,20,30,41 -> single valid after 4th, sample=25, digits 0,2,5.

Source files
------------

// File: rtl/adc_bcd_capture.sv
// rtl/adc_bcd_capture.sv - ADC0809 sample capture with binary-to-BCD conversion
//
// Captures the ADC data bus on a rising edge of the output-enable strobe,
// converts the value to three BCD digits with a sequential double-dabble
// (one iteration per clock, 8 clocks), then publishes the value and digits
// with a one-cycle valid pulse.
//
// Optional feature macro: ADC_AVG4_EN
//   When defined, four captures are summed and their truncated mean is
//   converted; the first three captures only accumulate.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   g_d      in   ADC output-enable strobe, adc_d valid while high
//   adc_d    in   8-bit ADC parallel data
//   sample   out  8-bit last converted value
//   bcd_h    out  hundreds digit of sample (0-2)
//   bcd_t    out  tens digit of sample
//   bcd_u    out  units digit of sample
//   valid    out  one-cycle pulse when sample and digits update
//   busy     out  conversion in progress
//   overrun  out  sticky: strobe edge seen while busy

module adc_bcd_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       g_d,
  input  logic [7:0] adc_d,
  output logic [7:0] sample,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u,
  output logic       valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        g_prev_q;
  logic [7:0]  bin_q;
  logic [7:0]  val_q;
  logic [11:0] bcd_q;
  logic [2:0]  iter_q;
  logic [7:0]  sample_q;
  logic [3:0]  bcd_h_q;
  logic [3:0]  bcd_t_q;
  logic [3:0]  bcd_u_q;
  logic        valid_q;
  logic        overrun_q;

  // Strobe is edge-qualified so a long g_d pulse starts a single capture.
  logic rise;
  assign rise = g_d & ~g_prev_q;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble step: correct each nibble, then shift {bcd,bin} left.
  logic [11:0] bcd_adj;
  logic [19:0] dabble;
  logic [11:0] bcd_d;
  logic [7:0]  bin_d;

  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    dabble  = {bcd_adj, bin_q} << 1;
    bcd_d   = dabble[19:8];
    bin_d   = dabble[7:0];
  end

`ifdef ADC_AVG4_EN
  logic [9:0] acc_q;
  logic [1:0] cap_q;
  logic [9:0] acc_d;
  logic       start;
  logic [7:0] start_val;

  // Four 8-bit samples sum to at most 1020, so 10 bits never overflow.
  assign acc_d     = acc_q + {2'b00, adc_d};
  assign start     = rise && (cap_q == 2'd3);
  assign start_val = acc_d[9:2];
`else
  logic       start;
  logic [7:0] start_val;

  assign start     = rise;
  assign start_val = adc_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_prev_q  <= 1'b0;
      bin_q     <= 8'd0;
      val_q     <= 8'd0;
      bcd_q     <= 12'd0;
      iter_q    <= 3'd0;
      sample_q  <= 8'd0;
      bcd_h_q   <= 4'd0;
      bcd_t_q   <= 4'd0;
      bcd_u_q   <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef ADC_AVG4_EN
      acc_q     <= 10'd0;
      cap_q     <= 2'd0;
`endif
    end else begin
      g_prev_q <= g_d;
      valid_q  <= 1'b0;

      case (state_q)
        IDLE: begin
`ifdef ADC_AVG4_EN
          if (rise) begin
            if (start) begin
              acc_q <= 10'd0;
              cap_q <= 2'd0;
            end else begin
              acc_q <= acc_d;
              cap_q <= cap_q + 2'd1;
            end
          end
`endif
          if (start) begin
            bin_q   <= start_val;
            val_q   <= start_val;
            bcd_q   <= 12'd0;
            iter_q  <= 3'd0;
            state_q <= CONV;
          end
        end

        CONV: begin
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          sample_q <= val_q;
          bcd_h_q  <= bcd_q[11:8];
          bcd_t_q  <= bcd_q[7:4];
          bcd_u_q  <= bcd_q[3:0];
          valid_q  <= 1'b1;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

      // A fresh strobe while a conversion runs is dropped but remembered.
      if (rise && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign sample  = sample_q;
  assign bcd_h   = bcd_h_q;
  assign bcd_t   = bcd_t_q;
  assign bcd_u   = bcd_u_q;
  assign valid   = valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_bcd_capture.sv
// tb/tb_adc_bcd_capture.sv - self-checking bench for adc_bcd_capture

module tb_adc_bcd_capture;

  logic       clk;
  logic       rst;
  logic       g_d;
  logic [7:0] adc_d;
  logic [7:0] sample;
  logic [3:0] bcd_h;
  logic [3:0] bcd_t;
  logic [3:0] bcd_u;
  logic       valid;
  logic       busy;
  logic       overrun;

  int vectors;
  int miscompares;
  int exp_q[$];

  adc_bcd_capture dut (
    .clk     (clk),
    .rst     (rst),
    .g_d     (g_d),
    .adc_d   (adc_d),
    .sample  (sample),
    .bcd_h   (bcd_h),
    .bcd_t   (bcd_t),
    .bcd_u   (bcd_u),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sample", int'(sample), e);
        check("bcd_h", int'(bcd_h), e / 100);
        check("bcd_t", int'(bcd_t), (e / 10) % 10);
        check("bcd_u", int'(bcd_u), e % 10);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe high for exactly one rising edge.
  task automatic pulse(input logic [7:0] v);
    @(negedge clk);
    g_d   = 1'b1;
    adc_d = v;
    @(negedge clk);
    g_d   = 1'b0;
    adc_d = 8'h5A;
  endtask

  // Called right after a converting pulse: valid only after the 9th edge.
  task automatic latency_check();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k < 9) begin
        check("lat_valid_low", int'(valid), 0);
        check("lat_busy_high", int'(busy), 1);
      end else begin
        check("lat_valid_high", int'(valid), 1);
        check("lat_busy_low", int'(busy), 0);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample"}, int'(sample), 0);
    check({tag, "_h"}, int'(bcd_h), 0);
    check({tag, "_t"}, int'(bcd_t), 0);
    check({tag, "_u"}, int'(bcd_u), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    g_d   = 1'b0;
    adc_d = 8'h00;
    idle(3);
    check_zero("reset");
    rst = 1'b0;
    idle(2);

`ifdef ADC_AVG4_EN
    // Captures 1-3 only accumulate.
    pulse(8'd10);
    idle(2);
    check("avg1_busy", int'(busy), 0);
    pulse(8'd20);
    idle(2);
    check("avg2_busy", int'(busy), 0);
    pulse(8'd30);
    idle(2);
    check("avg3_busy", int'(busy), 0);
    exp_q.push_back(25);
    pulse(8'd41);
    latency_check();
    idle(3);

    // Accumulator cleared after a conversion: full-scale mean.
    exp_q.push_back(255);
    for (int i = 0; i < 4; i++) begin
      pulse(8'hFF);
      idle(1);
    end
    idle(12);

    // Reset discards a partial accumulation.
    pulse(8'd100);
    idle(1);
    pulse(8'd100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("avg_rst");
    exp_q.push_back(8);
    for (int i = 0; i < 4; i++) begin
      pulse(8'd8);
      idle(1);
    end
    idle(12);
`else
    // Full scale, with cycle-exact latency.
    exp_q.push_back(255);
    pulse(8'hFF);
    latency_check();
    idle(3);

    exp_q.push_back(0);
    pulse(8'h00);
    idle(11);
    exp_q.push_back(123);
    pulse(8'h7B);
    idle(11);

    // Second strobe three cycles into a conversion.
    check("pre_overrun", int'(overrun), 0);
    exp_q.push_back(100);
    pulse(8'h64);
    idle(2);
    g_d   = 1'b1;
    adc_d = 8'h10;
    @(negedge clk);
    g_d   = 1'b0;
    idle(12);
    check("overrun_set", int'(overrun), 1);
    check("overrun_busy", int'(busy), 0);
    idle(3);
    check("overrun_sticky", int'(overrun), 1);

    // Reset four cycles into a conversion aborts it.
    pulse(8'hC8);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    idle(12);
    check("abort_busy", int'(busy), 0);
    exp_q.push_back(42);
    pulse(8'h2A);
    latency_check();
    idle(3);

    // Reset wins over a simultaneous strobe.
    @(negedge clk);
    rst   = 1'b1;
    g_d   = 1'b1;
    adc_d = 8'h63;
    @(negedge clk);
    rst = 1'b0;
    g_d = 1'b0;
    check("prio_busy", int'(busy), 0);
    idle(12);

    // Strobe held five cycles starts one conversion, no overrun.
    exp_q.push_back(5);
    @(negedge clk);
    g_d   = 1'b1;
    adc_d = 8'h05;
    idle(5);
    g_d = 1'b0;
    idle(12);
    check("hold_overrun", int'(overrun), 0);

    // A few arbitrary values.
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      exp_q.push_back(v);
      pulse(8'(v));
      idle(11);
    end
`endif

    idle(3);
    check("pending_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
